// File: rtl/vedic_mult4_pipe.sv
// ---------------------------------------------------------------------------
// vedic_mult4_pipe
//   Pipelined 4x4 unsigned multiplier using the Urdhva-Tiryagbhyam (vertical
//   and crosswise) decomposition. The multiplier is split into four 2x2 cells
//   whose partial products are combined by a half-adder ripple network. No
//   '*' operator is used anywhere in the datapath.
//
//   Pipeline:
//     S1  registers a, b, in_tag
//     S2  registers the four 2x2 partial products q0..q3 and the tag
//     S3  registers the 8-bit product and the tag (drives the outputs)
//
//   Handshake (both sides): a transfer happens on a rising clk edge where
//   valid && ready. The producer holds its payload stable while valid is
//   high and ready is low. Each stage advances independently through a
//   combinational ready chain, so a bubble in any stage is absorbed even while
//   the output is stalled. in_ready depends combinationally on out_ready.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       a/b/in_tag valid
//   in_ready   out  1       block accepts when in_valid && in_ready
//   a          in   4       multiplicand, unsigned
//   b          in   4       multiplier, unsigned
//   in_tag     in   TAG_W   sideband returned with the product
//   out_valid  out  1       product/out_tag valid
//   out_ready  in   1       consumer takes product when out_valid && out_ready
//   product    out  8       a*b, exact
//   out_tag    out  TAG_W   in_tag of the same transaction
//
// The file also holds the small cells the datapath is built from:
//   half_adder, vedic_mul2 (2x2 cell), ha_ripple_add (ripple adder made of
//   half adders).
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// half_adder: s = a ^ b, c = a & b
// ---------------------------------------------------------------------------
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// ---------------------------------------------------------------------------
// vedic_mul2: 2x2 unsigned multiply, q = a * b (4 bits).
//   q[0] is the vertical product of the low bits; the two crosswise terms are
//   summed by one half adder, whose carry joins the vertical product of the
//   high bits in a second half adder.
// ---------------------------------------------------------------------------
module vedic_mul2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] q
);
    logic cross_lo;
    logic cross_hi;
    logic top;
    logic c_mid;

    assign q[0]     = a[0] & b[0];
    assign cross_lo = a[1] & b[0];
    assign cross_hi = a[0] & b[1];
    assign top      = a[1] & b[1];

    half_adder u_ha_mid (
        .a (cross_lo),
        .b (cross_hi),
        .s (q[1]),
        .c (c_mid)
    );

    half_adder u_ha_top (
        .a (top),
        .b (c_mid),
        .s (q[2]),
        .c (q[3])
    );
endmodule

// ---------------------------------------------------------------------------
// ha_ripple_add: W-bit ripple adder, sum = (a + b) mod 2^W (W >= 2).
//   Bit 0 is a half adder, middle bits are full adders built from two half
//   adders and an OR. The top bit only needs its sum, so its carry is never
//   formed; callers size W so that the true result always fits.
// ---------------------------------------------------------------------------
module ha_ripple_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    // carry[i] is the carry into bit i
    logic [W-1:1] carry;

    half_adder u_ha_bit0 (
        .a (a[0]),
        .b (b[0]),
        .s (sum[0]),
        .c (carry[1])
    );

    for (genvar i = 1; i < W - 1; i++) begin : g_fa
        logic s_ab;
        logic c_ab;
        logic c_sc;

        half_adder u_ha_ab (
            .a (a[i]),
            .b (b[i]),
            .s (s_ab),
            .c (c_ab)
        );

        half_adder u_ha_sc (
            .a (s_ab),
            .b (carry[i]),
            .s (sum[i]),
            .c (c_sc)
        );

        assign carry[i+1] = c_ab | c_sc;
    end

    assign sum[W-1] = a[W-1] ^ b[W-1] ^ carry[W-1];
endmodule

// ---------------------------------------------------------------------------
// vedic_mult4_pipe: top level
// ---------------------------------------------------------------------------
module vedic_mult4_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       product,
    output logic [TAG_W-1:0] out_tag
);
    // ---------------- stage state ----------------
    logic             v1;
    logic [3:0]       a1;
    logic [3:0]       b1;
    logic [TAG_W-1:0] tag1;

    logic             v2;
    logic [3:0]       q0_r;
    logic [3:0]       q1_r;
    logic [3:0]       q2_r;
    logic [3:0]       q3_r;
    logic [TAG_W-1:0] tag2;

    logic             v3;
    logic [7:0]       prod3;
    logic [TAG_W-1:0] tag3;

    // ---------------- ready chain ----------------
    // A stage can load when it is empty or when its contents leave this cycle.
    logic rdy1;
    logic rdy2;
    logic rdy3;

    assign rdy3     = !v3 || out_ready;
    assign rdy2     = !v2 || rdy3;
    assign rdy1     = !v1 || rdy2;
    assign in_ready = rdy1;

    // ---------------- S1 -> S2 datapath: 2x2 cells ----------------
    // a = {ah, al}, b = {bh, bl}; a*b = al*bl + ((ah*bl + al*bh) << 2) + (ah*bh << 4)
    logic [3:0] q0_n;
    logic [3:0] q1_n;
    logic [3:0] q2_n;
    logic [3:0] q3_n;

    vedic_mul2 u_q0 (.a (a1[1:0]), .b (b1[1:0]), .q (q0_n));
    vedic_mul2 u_q1 (.a (a1[3:2]), .b (b1[1:0]), .q (q1_n));
    vedic_mul2 u_q2 (.a (a1[1:0]), .b (b1[3:2]), .q (q2_n));
    vedic_mul2 u_q3 (.a (a1[3:2]), .b (b1[3:2]), .q (q3_n));

    // ---------------- S2 -> S3 datapath: column sum ----------------
    // The low two bits of q0 pass straight through. Everything else is
    // weighted by 4, so the upper six product bits are
    //   {q3, q0[3:2]} + (q1 + q2).
    // q1 + q2 <= 18 fits in 5 bits; the upper sum <= 56 fits in 6 bits.
    logic [4:0] cross_sum;
    logic [5:0] upper_sum;
    logic [7:0] prod_n;

    ha_ripple_add #(.W(5)) u_add_cross (
        .a   ({1'b0, q1_r}),
        .b   ({1'b0, q2_r}),
        .sum (cross_sum)
    );

    ha_ripple_add #(.W(6)) u_add_upper (
        .a   ({q3_r, q0_r[3:2]}),
        .b   ({1'b0, cross_sum}),
        .sum (upper_sum)
    );

    assign prod_n = {upper_sum, q0_r[1:0]};

    // ---------------- S1 registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            tag1 <= '0;
        end else if (rdy1) begin
            v1   <= in_valid;
            a1   <= a;
            b1   <= b;
            tag1 <= in_tag;
        end
    end

    // ---------------- S2 registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            q0_r <= '0;
            q1_r <= '0;
            q2_r <= '0;
            q3_r <= '0;
            tag2 <= '0;
        end else if (rdy2) begin
            v2   <= v1;
            q0_r <= q0_n;
            q1_r <= q1_n;
            q2_r <= q2_n;
            q3_r <= q3_n;
            tag2 <= tag1;
        end
    end

    // ---------------- S3 registers ----------------
    // Held while out_valid && !out_ready, which keeps product/out_tag stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3    <= 1'b0;
            prod3 <= '0;
            tag3  <= '0;
        end else if (rdy3) begin
            v3    <= v2;
            prod3 <= prod_n;
            tag3  <= tag2;
        end
    end

    // ---------------- outputs ----------------
    assign out_valid = v3;
    assign product   = prod3;
    assign out_tag   = tag3;
endmodule

// File: tb/tb_vedic_mult4_pipe.sv
// ---------------------------------------------------------------------------
// tb_vedic_mult4_pipe
//   Directed and random stimulus for vedic_mult4_pipe. Every accepted operand
//   pair pushes its expected {tag, a*b} into exp_q; every output transfer pops
//   and compares. Directed steps add latency, backpressure, bubble, reset and
//   corner checks.
// ---------------------------------------------------------------------------
module tb_vedic_mult4_pipe;
    localparam int TAG_W = 4;

    // ---------------- clock / reset ----------------
    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       a;
    logic [3:0]       b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       product;
    logic [TAG_W-1:0] out_tag;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vedic_mult4_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out_tag   (out_tag)
    );

    // ---------------- scoreboard ----------------
    logic [TAG_W+7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int emits  = 0;

    // values sampled by the last step
    logic             s_ir;
    logic             s_ov;
    logic             s_acc;
    logic [7:0]       s_prod;
    logic [TAG_W-1:0] s_tag;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Drives at the falling edge, samples 1 ns later, so the following rising
    // edge sees exactly what was sampled.
    task automatic step(input logic iv, input logic [3:0] ia, input logic [3:0] ib,
                        input logic [TAG_W-1:0] it, input logic ordy);
        logic [7:0]       pe;
        logic [TAG_W+7:0] exp;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        in_tag    = it;
        out_ready = ordy;
        #1;
        s_ir   = in_ready;
        s_ov   = out_valid;
        s_prod = product;
        s_tag  = out_tag;
        s_acc  = iv && in_ready;
        if (out_valid && ordy) begin
            emits++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check("sb_product", 32'(product), 32'(exp[7:0]));
                check("sb_tag", 32'(out_tag), 32'(exp[TAG_W+7:8]));
            end
        end
        if (s_acc) begin
            pe = ia * ib;
            exp_q.push_back({it, pe});
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 4'd0, 4'd0, '0, ordy);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int e0;
        int ir_low;
        logic             pend;
        logic [3:0]       pa;
        logic [3:0]       pb;
        logic [TAG_W-1:0] pt;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_product", 32'(product), 0);
        check("rst_out_tag", 32'(out_tag), 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);

        // 1: single op, latency 3, out_valid for exactly one cycle
        step(1'b1, 4'd15, 4'd15, 4'd3, 1'b1);
        check("t1_accept", 32'(s_ir), 1);
        for (int k = 1; k <= 4; k++) begin
            idle(1'b1);
            check("t1_out_valid", 32'(s_ov), (k == 3) ? 1 : 0);
        end

        // 2: exhaustive stream, tag = a ^ b
        ir_low = 0;
        e0     = emits;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                step(1'b1, 4'(ai), 4'(bi), 4'(ai) ^ 4'(bi), 1'b1);
                if (!s_ir) ir_low++;
            end
        end
        check("t2_emits_in_stream", 32'(emits - e0), 253);
        repeat (3) idle(1'b1);
        check("t2_emits_total", 32'(emits - e0), 256);
        check("t2_in_ready_low", 32'(ir_low), 0);
        check("t2_queue_empty", 32'(exp_q.size()), 0);

        // 3: backpressure
        step(1'b1, 4'd3, 4'd5, 4'd1, 1'b1);
        step(1'b1, 4'd7, 4'd6, 4'd2, 1'b1);
        step(1'b1, 4'd2, 4'd9, 4'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'd4, 4'd4, 4'd4, 1'b0);
            check("t3_in_ready_full", 32'(s_ir), 0);
            check("t3_out_valid", 32'(s_ov), 1);
            check("t3_hold_product", 32'(s_prod), 15);
            check("t3_hold_tag", 32'(s_tag), 1);
        end
        step(1'b1, 4'd4, 4'd4, 4'd4, 1'b1);
        check("t3_in_ready_release", 32'(s_ir), 1);
        step(1'b1, 4'd11, 4'd13, 4'd5, 1'b1);
        repeat (6) idle(1'b1);
        check("t3_queue_empty", 32'(exp_q.size()), 0);

        // 4: bubble collapse under stall
        step(1'b1, 4'd5, 4'd3, 4'd7, 1'b0);
        check("t4_accept_a", 32'(s_ir), 1);
        idle(1'b0);
        step(1'b1, 4'd12, 4'd10, 4'd8, 1'b0);
        check("t4_accept_b", 32'(s_ir), 1);
        idle(1'b0);
        check("t4_ready_two_held", 32'(s_ir), 1);
        check("t4_out_valid", 32'(s_ov), 1);
        idle(1'b0);
        check("t4_ready_collapsed", 32'(s_ir), 1);
        step(1'b1, 4'd2, 4'd2, 4'd9, 1'b0);
        check("t4_accept_c", 32'(s_ir), 1);
        step(1'b1, 4'd9, 4'd9, 4'd10, 1'b0);
        check("t4_full", 32'(s_ir), 0);
        e0 = emits;
        step(1'b1, 4'd9, 4'd9, 4'd10, 1'b1);
        check("t4_accept_d", 32'(s_ir), 1);
        repeat (3) idle(1'b1);
        check("t4_back_to_back", 32'(emits - e0), 4);
        check("t4_queue_empty", 32'(exp_q.size()), 0);

        // 5: asynchronous reset mid-flight
        step(1'b1, 4'd13, 4'd11, 4'd5, 1'b0);
        step(1'b1, 4'd6, 4'd7, 4'd6, 1'b0);
        idle(1'b0);
        @(posedge clk);
        #2;
        check("t5_pre_valid", 32'(out_valid), 1);
        check("t5_pre_product", 32'(product), 143);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 0);
        check("t5_rst_product", 32'(product), 0);
        check("t5_rst_tag", 32'(out_tag), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        e0 = emits;
        repeat (6) idle(1'b1);
        check("t5_no_output", 32'(emits - e0), 0);

        // 6: corners
        step(1'b1, 4'd0, 4'd7, 4'd1, 1'b1);
        step(1'b1, 4'd9, 4'd0, 4'd2, 1'b1);
        step(1'b1, 4'd1, 4'd9, 4'd3, 1'b1);
        step(1'b1, 4'd8, 4'd8, 4'd4, 1'b1);
        step(1'b1, 4'd15, 4'd1, 4'd5, 1'b1);
        repeat (4) idle(1'b1);
        check("t6_queue_empty", 32'(exp_q.size()), 0);

        // random traffic with random backpressure; payload held until accepted
        pend = 1'b0;
        pa   = '0;
        pb   = '0;
        pt   = '0;
        for (int i = 0; i < 300; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pa   = 4'($urandom_range(0, 15));
                pb   = 4'($urandom_range(0, 15));
                pt   = TAG_W'($urandom_range(0, 15));
            end
            step(pend, pa, pb, pt, 1'($urandom_range(0, 3) != 0));
            if (s_acc) pend = 1'b0;
        end
        for (int i = 0; i < 10 && pend; i++) begin
            step(1'b1, pa, pb, pt, 1'b1);
            if (s_acc) pend = 1'b0;
        end
        check("rnd_sent", 32'(pend), 0);
        repeat (5) idle(1'b1);
        check("rnd_queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
